// File: rtl/line_fetch_sched_pkg.sv
// Shared definitions for the line fetch scheduler: FSM encoding and the
// burst-geometry helpers used to size counters and address steps.
package line_fetch_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_REQ   = 2'd2,
      S_DATA  = 2'd3
   } fetch_state_t;

   localparam int DEF_H_ACTIVE      = 1280;
   localparam int DEF_BURST_LEN     = 256;
   localparam int DEF_BYTES_PER_PIX = 4;

   localparam int DEF_BURSTS      = DEF_H_ACTIVE / DEF_BURST_LEN;
   localparam int DEF_BURST_BYTES = DEF_BURST_LEN * DEF_BYTES_PER_PIX;

   function automatic int bursts_of(input int h_active, input int burst_len);
      return h_active / burst_len;
   endfunction

   function automatic int burst_bytes_of(input int burst_len, input int bytes_per_pix);
      return burst_len * bytes_per_pix;
   endfunction

   // A line must split into a whole, non-zero number of bursts.
   function automatic bit burst_divides(input int h_active, input int burst_len);
      return (burst_len > 0) && (h_active >= burst_len) && ((h_active % burst_len) == 0);
   endfunction

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/line_fetch_sched_sync_edge_det.sv
// Registers one timing-generator strobe and emits single-cycle rise/fall
// pulses comparing the live input against its registered copy.
module sync_edge_det
   import line_fetch_sched_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic r_sig;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sig <= 1'b0;
      end else begin
         r_sig <= i_sig;
      end
   end

   assign o_rise = i_sig & ~r_sig;
   assign o_fall = ~i_sig & r_sig;

endmodule

// File: rtl/line_fetch_sched.sv
// Fetches each active line as fixed-size read bursts into a ping-pong line
// buffer pair, swaps on every displayed line and restarts on vertical sync.
module line_fetch_sched
   import line_fetch_sched_pkg::*;
#(
   parameter int          H_ACTIVE      = 1280,
   parameter int          V_ACTIVE      = 720,
   parameter int          BURST_LEN     = 256,
   parameter int          BYTES_PER_PIX = 4,
   parameter int          ADDR_W        = 32,
   parameter int unsigned FRAME_BASE    = 0,
   parameter bit          VS_POL        = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_vs_in,
   input  logic              i_de_in,
   output logic              o_rd_req,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic [15:0]       o_rd_len,
   input  logic              i_rd_ack,
   input  logic              i_rd_done,
   output logic              o_buf_wr_sel,
   output logic              o_buf_rd_sel,
   output logic              o_line_ready,
   output logic              o_frame_start,
   output logic              o_underflow
);

   localparam int BURSTS      = bursts_of(H_ACTIVE, BURST_LEN);
   localparam int BURST_BYTES = burst_bytes_of(BURST_LEN, BYTES_PER_PIX);
   localparam int FL_W        = $clog2(V_ACTIVE + 1);
   localparam int BC_W        = clog2_min1(BURSTS);

   localparam logic [FL_W-1:0]   LAST_LINE  = FL_W'(V_ACTIVE);
   localparam logic [BC_W-1:0]   LAST_BURST = BC_W'(BURSTS - 1);
   localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(FRAME_BASE);
   localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_BYTES);

   generate
      if (!burst_divides(H_ACTIVE, BURST_LEN)) begin : g_bad_burst_geometry
         $error("H_ACTIVE must be a non-zero multiple of BURST_LEN");
      end
   endgenerate

   fetch_state_t      r_state;
   logic [1:0]        r_full;
   logic              r_wr_sel;
   logic              r_rd_sel;
   logic              r_req;
   logic              r_restart_pend;
   logic              r_line_ready;
   logic              r_frame_start;
   logic              r_underflow;
   logic [FL_W-1:0]   r_fetch_line;
   logic [BC_W-1:0]   r_burst_cnt;
   logic [ADDR_W-1:0] r_addr;

   logic w_vs_rise, w_vs_fall, w_de_rise, w_de_fall;
   logic w_vs_edge, w_pend, w_burst_done, w_line_done, w_restart;
   logic w_disp_en, w_disp_rise, w_disp_fall;
   logic [1:0] w_set, w_clr, w_full_next;

   sync_edge_det u_vs_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sig  (i_vs_in),
      .o_rise (w_vs_rise),
      .o_fall (w_vs_fall)
   );

   sync_edge_det u_de_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sig  (i_de_in),
      .o_rise (w_de_rise),
      .o_fall (w_de_fall)
   );

   assign w_vs_edge    = VS_POL ? w_vs_rise : w_vs_fall;
   // A sync arriving in the same cycle as rd_done must already discard that burst.
   assign w_pend       = r_restart_pend | w_vs_edge;
   assign w_burst_done = (r_state == S_DATA) & i_rd_done;
   assign w_line_done  = w_burst_done & ~w_pend & (r_burst_cnt == LAST_BURST);
   assign w_restart    = (w_vs_edge & ((r_state == S_IDLE) | (r_state == S_CHECK)))
                       | (w_burst_done & w_pend);

   // Once the frame is fully fetched and displayed, stray de activity is ignored.
   assign w_disp_en   = !((r_state == S_IDLE) && (r_fetch_line == LAST_LINE) && (r_full == 2'b00));
   assign w_disp_rise = w_de_rise & w_disp_en;
   assign w_disp_fall = w_de_fall & w_disp_en;

   assign w_set       = {w_line_done & r_wr_sel, w_line_done & ~r_wr_sel};
   assign w_clr       = {w_disp_fall & r_rd_sel, w_disp_fall & ~r_rd_sel};
   assign w_full_next = (r_full & ~w_clr) | w_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_full         <= 2'b00;
         r_wr_sel       <= 1'b0;
         r_rd_sel       <= 1'b0;
         r_req          <= 1'b0;
         r_restart_pend <= 1'b0;
         r_line_ready   <= 1'b0;
         r_frame_start  <= 1'b0;
         r_underflow    <= 1'b0;
         r_fetch_line   <= '0;
         r_burst_cnt    <= '0;
         r_addr         <= '0;
      end else begin
         r_frame_start <= w_vs_edge;
         r_line_ready  <= r_full[r_rd_sel];
         if (w_restart) begin
            r_full         <= 2'b00;
            r_wr_sel       <= 1'b0;
            r_rd_sel       <= 1'b0;
            r_req          <= 1'b0;
            r_restart_pend <= 1'b0;
            r_underflow    <= 1'b0;
            r_fetch_line   <= '0;
            r_burst_cnt    <= '0;
            r_addr         <= BASE_ADDR;
            r_state        <= S_CHECK;
         end else begin
            r_full <= w_full_next;
            if (w_disp_fall) begin
               r_rd_sel <= ~r_rd_sel;
            end
            if (w_disp_rise && !r_full[r_rd_sel]) begin
               r_underflow <= 1'b1;
            end
            if (w_vs_edge) begin
               r_restart_pend <= 1'b1;
            end
            case (r_state)
               S_IDLE: begin
                  r_state <= S_IDLE;
               end
               S_CHECK: begin
                  if (r_fetch_line == LAST_LINE) begin
                     r_state <= S_IDLE;
                  end else if (!r_full[r_wr_sel]) begin
                     r_req   <= 1'b1;
                     r_state <= S_REQ;
                  end
               end
               S_REQ: begin
                  if (i_rd_ack) begin
                     r_req   <= 1'b0;
                     r_state <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (i_rd_done) begin
                     r_addr <= r_addr + ADDR_STEP;
                     if (r_burst_cnt == LAST_BURST) begin
                        r_wr_sel     <= ~r_wr_sel;
                        r_fetch_line <= r_fetch_line + FL_W'(1);
                        r_burst_cnt  <= '0;
                        r_state      <= S_CHECK;
                     end else begin
                        r_burst_cnt <= r_burst_cnt + BC_W'(1);
                        r_req       <= 1'b1;
                        r_state     <= S_REQ;
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign o_rd_req      = r_req;
   assign o_rd_addr     = r_addr;
   assign o_rd_len      = 16'(BURST_LEN);
   assign o_buf_wr_sel  = r_wr_sel;
   assign o_buf_rd_sel  = r_rd_sel;
   assign o_line_ready  = r_line_ready;
   assign o_frame_start = r_frame_start;
   assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_line_fetch_sched.sv
// Directed bench for line_fetch_sched: drives the memory handshake and the
// de/vs strobes step by step and checks outputs against hand-worked values.
`timescale 1ns/1ps
module tb_line_fetch_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_vs_in = 1'b0;
   logic        i_de_in = 1'b0;
   logic        i_rd_ack = 1'b0;
   logic        i_rd_done = 1'b0;
   logic        o_rd_req;
   logic [31:0] o_rd_addr;
   logic [15:0] o_rd_len;
   logic        o_buf_wr_sel;
   logic        o_buf_rd_sel;
   logic        o_line_ready;
   logic        o_frame_start;
   logic        o_underflow;

   int   n_vec = 0;
   int   n_err = 0;
   int   fs_cnt = 0;
   int   req_cnt = 0;
   logic req_prev = 1'b0;

   line_fetch_sched dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_vs_in       (i_vs_in),
      .i_de_in       (i_de_in),
      .o_rd_req      (o_rd_req),
      .o_rd_addr     (o_rd_addr),
      .o_rd_len      (o_rd_len),
      .i_rd_ack      (i_rd_ack),
      .i_rd_done     (i_rd_done),
      .o_buf_wr_sel  (o_buf_wr_sel),
      .o_buf_rd_sel  (o_buf_rd_sel),
      .o_line_ready  (o_line_ready),
      .o_frame_start (o_frame_start),
      .o_underflow   (o_underflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_frame_start === 1'b1) fs_cnt++;
      if (o_rd_req === 1'b1 && req_prev !== 1'b1) req_cnt++;
      req_prev = o_rd_req;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(output bit ok);
      int n;
      n = 0;
      while (o_rd_req !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      ok = (o_rd_req === 1'b1);
   endtask

   task automatic req_ack(input int ack_dly, input bit chk, input logic [31:0] e_addr,
                          output logic [31:0] got, output bit ok);
      wait_req(ok);
      got = o_rd_addr;
      if (chk) check("req_seen", 32'(ok), 32'd1);
      if (!ok) return;
      if (chk) check("rd_addr", o_rd_addr, e_addr);
      for (int i = 0; i < ack_dly; i++) begin
         @(negedge clk);
         if (chk && ack_dly > 2) begin
            check("req_hold", 32'(o_rd_req), 32'd1);
            check("addr_hold", o_rd_addr, e_addr);
         end
      end
      i_rd_ack = 1'b1;
      @(negedge clk);
      i_rd_ack = 1'b0;
      if (chk) check("req_drop", 32'(o_rd_req), 32'd0);
   endtask

   task automatic done_after(input int dly, input bit chk);
      for (int i = 0; i < dly; i++) @(negedge clk);
      if (chk) check("one_data", 32'(o_rd_req), 32'd0);
      i_rd_done = 1'b1;
      @(negedge clk);
      i_rd_done = 1'b0;
   endtask

   task automatic fetch(input int line, input int b0, input int b1, input int ack_dly, input int done_dly);
      logic [31:0] got;
      bit ok;
      for (int b = b0; b <= b1; b++) begin
         req_ack(ack_dly, 1'b1, 32'(line * 5120 + b * 1024), got, ok);
         if (!ok) return;
         done_after(done_dly, 1'b1);
      end
   endtask

   task automatic de_pulse();
      i_de_in = 1'b1;
      tick(3);
      i_de_in = 1'b0;
      tick(2);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] e_addr;
      bit ok;
      int bad;
      int base;

      // reset values
      tick(3);
      check("rst_rd_req", 32'(o_rd_req), 32'd0);
      check("rst_rd_addr", o_rd_addr, 32'd0);
      check("rst_rd_len", 32'(o_rd_len), 32'd256);
      check("rst_wr_sel", 32'(o_buf_wr_sel), 32'd0);
      check("rst_rd_sel", 32'(o_buf_rd_sel), 32'd0);
      check("rst_line_ready", 32'(o_line_ready), 32'd0);
      check("rst_frame_start", 32'(o_frame_start), 32'd0);
      check("rst_underflow", 32'(o_underflow), 32'd0);
      rst_n = 1'b1;
      tick(5);
      check("idle_no_req", 32'(o_rd_req), 32'd0);

      // first line: five bursts at 0x0..0x1000
      i_vs_in = 1'b1;
      tick(1);
      check("frame_start", 32'(o_frame_start), 32'd1);
      tick(1);
      check("frame_start_1cyc", 32'(o_frame_start), 32'd0);
      i_vs_in = 1'b0;
      fetch(0, 0, 4, 2, 20);
      check("wr_sel_after_l0", 32'(o_buf_wr_sel), 32'd1);
      tick(1);
      check("line_ready_l0", 32'(o_line_ready), 32'd1);
      check("fs_cnt_1", 32'(fs_cnt), 32'd1);

      // both buffers full, no de: fetch stalls
      fetch(1, 0, 4, 2, 20);
      check("wr_sel_after_l1", 32'(o_buf_wr_sel), 32'd0);
      tick(10);
      check("stall_no_req", 32'(o_rd_req), 32'd0);
      check("stall_rd_sel", 32'(o_buf_rd_sel), 32'd0);
      de_pulse();
      check("swap_rd_sel", 32'(o_buf_rd_sel), 32'd1);
      check("no_underflow", 32'(o_underflow), 32'd0);

      // line 2 with ack withheld for 50 cycles
      req_ack(50, 1'b1, 32'h2800, got, ok);
      done_after(20, 1'b1);
      fetch(2, 1, 4, 2, 20);

      // slow memory on line 3 with display catching the unfilled buffer
      de_pulse();
      req_ack(0, 1'b1, 32'h3C00, got, ok);
      de_pulse();
      check("pre_uf", 32'(o_underflow), 32'd0);
      check("pre_uf_rd_sel", 32'(o_buf_rd_sel), 32'd1);
      i_de_in = 1'b1;
      tick(3);
      check("underflow_set", 32'(o_underflow), 32'd1);
      tick(2000);
      check("slow_no_req", 32'(o_rd_req), 32'd0);
      i_de_in = 1'b0;
      tick(1);
      done_after(0, 1'b0);
      check("uf_rd_sel", 32'(o_buf_rd_sel), 32'd0);
      check("underflow_sticky", 32'(o_underflow), 32'd1);

      // vsync during line 3 burst 2: completion dropped, frame restarts
      fetch(3, 1, 1, 2, 20);
      req_ack(2, 1'b1, 32'h4400, got, ok);
      tick(3);
      i_vs_in = 1'b1;
      tick(1);
      check("frame_start_2", 32'(o_frame_start), 32'd1);
      i_vs_in = 1'b0;
      tick(5);
      check("uf_until_restart", 32'(o_underflow), 32'd1);
      done_after(20, 1'b1);
      check("restart_uf_clr", 32'(o_underflow), 32'd0);
      check("restart_wr_sel", 32'(o_buf_wr_sel), 32'd0);
      check("restart_rd_sel", 32'(o_buf_rd_sel), 32'd0);
      check("restart_addr", o_rd_addr, 32'd0);
      tick(1);
      check("restart_line_ready", 32'(o_line_ready), 32'd0);
      check("fs_cnt_2", 32'(fs_cnt), 32'd2);
      base = req_cnt;

      // full frame with fast memory, display draining one line behind
      bad = 0;
      ok = 1'b1;
      for (int l = 0; l < 720 && ok; l++) begin
         if (l >= 2) de_pulse();
         for (int b = 0; b < 5 && ok; b++) begin
            e_addr = 32'(l * 5120 + b * 1024);
            req_ack(0, (l == 0 && b == 0), e_addr, got, ok);
            if (ok && got !== e_addr) bad++;
            if (ok) done_after(0, 1'b0);
         end
      end
      check("frame_all_reqs_seen", 32'(ok), 32'd1);
      check("frame_bad_addrs", 32'(bad), 32'd0);
      check("frame_final_addr", o_rd_addr, 32'd3686400);
      tick(3);
      check("frame_idle_no_req", 32'(o_rd_req), 32'd0);
      check("frame_req_count", 32'(req_cnt - base), 32'd3600);
      check("frame_no_underflow", 32'(o_underflow), 32'd0);

      // drain both buffers, then de in finished frame is ignored
      de_pulse();
      de_pulse();
      check("drain_rd_sel", 32'(o_buf_rd_sel), 32'd0);
      check("drain_line_ready", 32'(o_line_ready), 32'd0);
      de_pulse();
      check("idle_de_ignored", 32'(o_buf_rd_sel), 32'd0);
      check("idle_no_uf", 32'(o_underflow), 32'd0);
      check("idle_still_no_req", 32'(o_rd_req), 32'd0);

      // next vsync restarts from IDLE
      i_vs_in = 1'b1;
      tick(1);
      check("frame_start_3", 32'(o_frame_start), 32'd1);
      i_vs_in = 1'b0;
      wait_req(ok);
      check("new_frame_req", 32'(ok), 32'd1);
      check("new_frame_addr", o_rd_addr, 32'd0);
      tick(3);
      check("fs_cnt_3", 32'(fs_cnt), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
